// File: rtl/tdm_pkg.sv
// Shared definitions for the 8:1 TDM select-link receiver.
// The slot count, the index width and the frame-alignment states live here.
package tdm_pkg;

    localparam int N_SLOTS = 8;
    localparam int SEL_W   = 3;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/tdm_slot_counter.sv
// Wrapping slot index counter for the TDM receiver.
// Loading on sync always restarts at 1, because the sync bit itself fills slot 0.
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int N = N_SLOTS,
    parameter int W = SEL_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         load,
    output logic [W-1:0] sel,
    output logic         last
);

    logic [W-1:0] sel_q;
    logic [W-1:0] sel_d;

    always_comb begin
        sel_d = sel_q;
        if (load) begin
            sel_d = W'(1);
        end else if (inc) begin
            sel_d = sel_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_q <= '0;
        end else begin
            sel_q <= sel_d;
        end
    end

    assign sel  = sel_q;
    assign last = (sel_q == W'(N - 1));

endmodule

// File: rtl/tdm_demux_1to8.sv
// Receive end of the 8:1 serial select link: reassembles slot bits into a word.
// Completed words sit in a valid/ready output register; overruns and resyncs are flagged.
module tdm_demux_1to8
    import tdm_pkg::*;
#(
    parameter int N     = N_SLOTS,
    parameter int SEL_W = tdm_pkg::SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             d,
    input  logic             sync,
    output logic [SEL_W-1:0] sel,
    output logic [N-1:0]     y,
    output logic             y_valid,
    input  logic             y_ready,
    output logic             ovr,
    output logic             sync_err
);

    state_t         state_q, state_d;
    logic [N-1:0]   shadow_q, shadow_d;
    logic [N-1:0]   y_q, y_d;
    logic           y_valid_q, y_valid_d;
    logic           ovr_q, ovr_d;
    logic           sync_err_q, sync_err_d;

    logic [SEL_W-1:0] slot_sel;
    logic             slot_last;
    logic             slot_inc;
    logic             slot_load;
    logic             complete;
    logic [N-1:0]     word;

    tdm_slot_counter #(
        .N (N),
        .W (SEL_W)
    ) u_slot_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (slot_inc),
        .load  (slot_load),
        .sel   (slot_sel),
        .last  (slot_last)
    );

    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        y_d        = y_q;
        y_valid_d  = y_valid_q;
        ovr_d      = ovr_q;
        sync_err_d = 1'b0;
        slot_inc   = 1'b0;
        slot_load  = 1'b0;
        complete   = 1'b0;
        word       = {d, shadow_q[N-2:0]};

        if (en) begin
            if (sync) begin
                // Any sync restarts the frame; only a sync away from slot 0 in RUN is an error.
                slot_load   = 1'b1;
                shadow_d    = '0;
                shadow_d[0] = d;
                state_d     = RUN;
                if (state_q == RUN && slot_sel != '0) begin
                    sync_err_d = 1'b1;
                end
            end else if (state_q == RUN) begin
                slot_inc           = 1'b1;
                shadow_d[slot_sel] = d;
                complete           = slot_last;
            end
        end

        if (complete) begin
            if (!y_valid_q || y_ready) begin
                y_d       = word;
                y_valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (y_valid_q && y_ready) begin
            y_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= HUNT;
            shadow_q   <= '0;
            y_q        <= '0;
            y_valid_q  <= 1'b0;
            ovr_q      <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            y_q        <= y_d;
            y_valid_q  <= y_valid_d;
            ovr_q      <= ovr_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign sel      = slot_sel;
    assign y        = y_q;
    assign y_valid  = y_valid_q;
    assign ovr      = ovr_q;
    assign sync_err = sync_err_q;

endmodule

// File: doc/tdm_demux_1to8.md
Name: tdm_demux_1to8

Overview:
- Receive end of the 8:1 serial select link: an upstream 8:1 mux scans select 0..7 and drives one bit per slot; this block reassembles the 8 slot bits into a parallel word.
- Slot k lands in y[k], so y = a on the far side.
- Frame alignment comes from a sync strobe on slot 0.
- Completed words are offered on a valid/ready output register, with overrun and resync error reporting.

Parameters:
- N, 8, number of slots per frame (power of two, N >= 2).
- SEL_W, 3, slot index width, equal to log2(N).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- en  input  1  slot strobe; d and sync are sampled only when en=1.
- d  input  1  serial data bit for the current slot.
- sync  input  1  marks the current bit as slot 0; qualified by en.
- sel  output  SEL_W  slot index expected on the next en=1 cycle; usable as s for a local mux.
- y  output  N  assembled word; bit k is slot k.
- y_valid  output  1  y holds an unconsumed word.
- y_ready  input  1  consumer accepts y when y_valid=1 and y_ready=1.
- ovr  output  1  sticky overrun flag.
- sync_err  output  1  one-cycle pulse on a misaligned sync.

Behaviour:
- Reset (rst_n=0 at a clk edge) clears every register: state=HUNT, sel=0, shadow=0, y=0, y_valid=0, ovr=0, sync_err=0.
  - Reset mid-frame discards the partial frame.
  - Reset overrides all other inputs in that cycle.
- en=0 cycle: no sampling. sel, shadow and state hold. The y/y_valid handshake still operates.
- State HUNT:
  - en=1 and sync=0: bit ignored, sel stays 0.
  - en=1 and sync=1: shadow[0]=d, sel=1, next state RUN.
- State RUN, en=1, sync=0: shadow[sel]=d, sel=sel+1, wrapping N-1 to 0.
- State RUN, en=1, sync=1:
  - sel=0: normal slot 0, aligned.
  - sel!=0: the partial frame is discarded, sync_err=1 for the next cycle, shadow[0]=d, sel=1, state stays RUN.
- Frame complete: RUN, en=1, sel=N-1, sync=0.
  - On the same edge, word = {d, shadow[N-2:0]} is offered.
  - If y_valid=0, or y_valid=1 and y_ready=1: y=word and y_valid=1. This includes a simultaneous accept and complete, which causes no overrun.
  - If y_valid=1 and y_ready=0: the word is dropped, y is held and ovr is set to 1.
- Latency: y_valid rises on the clk edge that samples slot N-1. y is visible the cycle after the last bit is presented.
- Accept without a new word (y_valid=1, y_ready=1, no completion): y_valid=0 next cycle, y held.
- ovr stays set until reset. No other clear.
- sync_err is asserted only for the one cycle after a misaligned sync. Back-to-back misaligned syncs give back-to-back pulses.
- y_ready while y_valid=0 has no effect.
- sel is registered and has no combinational path from the inputs.

Decomposition:
- Shared package tdm_pkg holds:
  - constants N_SLOTS=8 and SEL_W=3;
  - the state enum {HUNT, RUN};
  - the slot index typedef sel_t.
- One natural sub-module, tdm_slot_counter:
  - the SEL_W-bit wrapping counter with en, a load-to-1 on sync, and a synchronous active-low clear;
  - outputs sel and last = (sel==N-1).
- Word assembly, the handshake and the flags stay in the top module.

Test Plan:
- Reset: hold rst_n=0 for 2 clk with en=1, sync=1, d=1 -> y=0x00, y_valid=0, ovr=0, sync_err=0, sel=0. No capture.
- Basic frame: en=1, sync=1 on slot 0, d=0,1,0,1,0,1,0,1 for slots 0..7, y_ready=0 -> after the 8th edge y=0xAA, y_valid=1. sel sequence 1..7 then 0.
- Backpressure: y_ready=0, a second frame 0x55 completes -> y stays 0xAA and ovr=1. Raise y_ready -> y_valid falls, ovr stays 1 until reset.
- Simultaneous accept: y_valid=1 with y=0xAA, y_ready=1 on the edge completing 0x0F -> y=0x0F, y_valid=1, ovr unchanged (0).
- Resync: sync at slot 3 with d=1, then 7 more bits all 0 -> sync_err pulses once, the old partial frame is lost, the next word is y=0x01.
- en gaps and HUNT: d=1 for 20 en=1 cycles with no sync -> y_valid stays 0. Then a frame 0xC3 is sent with en=0 inserted between every slot -> y=0xC3, and sel holds during every en=0 cycle.
